// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stall/flush control, E-stage forwarding and a
// data-memory handshake watchdog that locks the pipe in ERR after too many wait cycles.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemBusy,
  output logic              MemTimeoutErr
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WCNT_ONE  = CW'(1);
  localparam logic [CW-1:0] WCNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          mem_busy_q, mem_err_q;
  logic          mem_wait, mem_stall, lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              wr_m,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              wr_w,
                                         input logic [REG_AW-1:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != '0) && (rd_m == rs))      sel = 2'b10;
    else if (wr_w && (rd_w != '0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  assign mem_wait  = MemReqM & ~MemReadyM;
  assign mem_stall = (state_q == ERR) | mem_wait;
  assign lw_stall  = (ResultSrcE == 2'b01) & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // A memory stall freezes the whole pipe, so branch and load-use actions wait for release.
  always_comb begin
    StallF = lw_stall;
    StallD = lw_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = PCSrcE;
    FlushE = lw_stall | PCSrcE;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_ONE;
        end
      end
      MEM_WAIT: begin
        // A dropped request is a protocol violation; recover rather than hang.
        if (MemReadyM || !MemReqM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      ERR: state_d = ERR;
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wcnt_q     <= '0;
      mem_busy_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      mem_busy_q <= (state_d == MEM_WAIT);
      mem_err_q  <= (state_d == ERR);
    end
  end

  assign MemBusy       = mem_busy_q;
  assign MemTimeoutErr = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4): the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on each falling edge.
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MemBusy, MemTimeoutErr;

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemBusy(MemBusy), .MemTimeoutErr(MemTimeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [12:0] e;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  logic [12:0] act;

  // stall field order F,D,E,M; flush field order D,E,W
  localparam logic [3:0] S0 = 4'b0000, SFD = 4'b1100, SALL = 4'b1111;
  localparam logic [2:0] F0 = 3'b000, FE = 3'b010, FDE = 3'b110, FW = 3'b001;

  function automatic logic [12:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic bz, input logic er);
    return {st, fl, fa, fb, bz, er};
  endfunction

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [12:0] e);
    exp_t x;
    x.nm = nm;
    x.e  = e;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        m   = sb_q.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemBusy, MemTimeoutErr};
        checks++;
        if (act !== m.e) begin
          errors++;
          $display("FAIL %s: got %b expected %b", m.nm, act, m.e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    cyc("reset", mk(S0, F0, 2'b00, 2'b00, 0, 0));
    rst_n = 1'b1;
    cyc("idle", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // load-use
    ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
    cyc("lw_rs1", mk(SFD, FE, 2'b00, 2'b00, 0, 0));
    Rs1D = 3; Rs2D = 5;
    cyc("lw_rs2", mk(SFD, FE, 2'b00, 2'b00, 0, 0));
    RdE = 0; Rs2D = 0;
    cyc("lw_rd0", mk(S0, F0, 2'b00, 2'b00, 0, 0));
    RdE = 5; Rs2D = 5; ResultSrcE = 2'b00;
    cyc("no_load", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // branch
    idle(); PCSrcE = 1;
    cyc("branch", mk(S0, FDE, 2'b00, 2'b00, 0, 0));
    ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
    cyc("branch_lw", mk(SFD, FDE, 2'b00, 2'b00, 0, 0));
    idle(); PCSrcE = 1; MemReqM = 1;
    cyc("branch_mem1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    cyc("branch_mem2", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    MemReadyM = 1;
    cyc("branch_ack", mk(S0, FDE, 2'b00, 2'b00, 1, 0));
    idle();
    cyc("branch_done", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // forwarding
    RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7;
    cyc("fwd_m", mk(S0, F0, 2'b10, 2'b00, 0, 0));
    RegWriteM = 0;
    cyc("fwd_w", mk(S0, F0, 2'b01, 2'b00, 0, 0));
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    cyc("fwd_rd0", mk(S0, F0, 2'b00, 2'b00, 0, 0));
    RdM = 9; RdW = 9; Rs2E = 9; Rs1E = 6;
    cyc("fwd_bm", mk(S0, F0, 2'b00, 2'b10, 0, 0));
    RdM = 6;
    cyc("fwd_split", mk(S0, F0, 2'b10, 2'b01, 0, 0));
    idle();

    // mem wait, ack in 3rd cycle
    MemReqM = 1;
    cyc("mw_c1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    cyc("mw_c2", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    MemReadyM = 1;
    cyc("mw_ack", mk(S0, F0, 2'b00, 2'b00, 1, 0));
    idle();
    cyc("mw_run", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // ack on the last allowed cycle
    MemReqM = 1;
    cyc("late_c1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    cyc("late_c2", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    cyc("late_c3", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    MemReadyM = 1;
    cyc("late_ack", mk(S0, F0, 2'b00, 2'b00, 1, 0));
    idle();
    cyc("late_run", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // dropped request while waiting
    MemReqM = 1;
    cyc("drop_c1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    MemReqM = 0;
    cyc("drop_c2", mk(S0, F0, 2'b00, 2'b00, 1, 0));
    cyc("drop_run", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // async reset during MEM_WAIT
    MemReqM = 1;
    cyc("rstw_c1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    cyc("rstw_c2", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    idle(); rst_n = 1'b0;
    cyc("rstw_async", mk(S0, F0, 2'b00, 2'b00, 0, 0));
    rst_n = 1'b1;
    cyc("rstw_run", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    // timeout into ERR
    MemReqM = 1;
    cyc("to_c1", mk(SALL, FW, 2'b00, 2'b00, 0, 0));
    cyc("to_c2", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    cyc("to_c3", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    cyc("to_c4", mk(SALL, FW, 2'b00, 2'b00, 1, 0));
    idle();
    cyc("err_noreq", mk(SALL, FW, 2'b00, 2'b00, 0, 1));
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 2; Rs1D = 2;
    cyc("err_sticky", mk(SALL, FW, 2'b00, 2'b00, 0, 1));
    idle(); rst_n = 1'b0;
    cyc("err_async_rst", mk(S0, F0, 2'b00, 2'b00, 0, 0));
    rst_n = 1'b1;
    cyc("err_cleared", mk(S0, F0, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < 5; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
